// File: rtl/cpu_ctrl_seq.sv
// Multicycle fetch/decode/execute/mem/write-back/interrupt control sequencer.
// Define CPU_CTRL_TIMEOUT_EN to build the bus-timeout counter, the BERR state and a live bus_err_o.
module cpu_ctrl_seq #(
  parameter int IR_W       = 18,
  parameter int INT_CYCLES = 1,
  parameter int TO_W       = 8,
  parameter int TO_LIMIT   = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IR_W-1:0] ir_i,
  input  logic            inst_ack_i,
  input  logic            data_ack_i,
  input  logic            port_ack_i,
  input  logic            int_req_i,
  input  logic            int_en_i,
  output logic            inst_cyc_o,
  output logic            data_cyc_o,
  output logic            data_we_o,
  output logic            port_cyc_o,
  output logic            port_we_o,
  output logic            reg_we_o,
  output logic            int_ack_o,
  output logic            bus_err_o,
  output logic [2:0]      state_o,
  output logic [2:0]      next_state_o
);

  localparam int M = IR_W - 1;
  localparam logic [3:0] INT_LAST = 4'(INT_CYCLES - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    INT    = 3'b101,
    BERR   = 3'b110
  } state_t;

  state_t     state_r;
  state_t     next_s;
  state_t     irq_target_s;
  state_t     mem_done_s;
  logic [3:0] int_cnt_r;
  logic       irq_s;
  logic       is_mem_s;
  logic       is_ctl_s;
  logic       is_halt_s;
  logic [1:0] mem_fn_s;
  logic       mem_ack_s;
  logic       bus_phase_s;
  logic       to_fire_s;
  logic       ir_unused_s;

  // Opcode fields are anchored at the instruction MSB so IR_W can grow without re-decoding.
  assign is_mem_s  = (ir_i[M:M-1] == 2'b10);
  assign is_halt_s = (ir_i[M:M-6] == 7'b1111110) && (ir_i[M-7:M-8] == 2'b10);
  assign is_ctl_s  = (ir_i[M:M-4] == 5'b11110) || (ir_i[M:M-5] == 6'b111110) ||
                     (ir_i[M:M-6] == 7'b1111110);
  assign mem_fn_s  = ir_i[M-2:M-3];
  assign mem_ack_s = mem_fn_s[1] ? port_ack_i : data_ack_i;
  assign irq_s     = int_en_i & int_req_i;
  assign ir_unused_s = ^ir_i[M-10:0];

  assign irq_target_s = irq_s ? INT : FETCH;
  assign mem_done_s   = mem_fn_s[0] ? irq_target_s : WB;
  assign bus_phase_s  = (next_s == EXEC) || (next_s == MEM);

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  logic [TO_W-1:0] to_cnt_r;
  // Fires on the last permitted wait cycle; callers give the ack priority.
  assign to_fire_s = (to_cnt_r == TO_LAST);
`else
  localparam int to_cfg_unused = TO_W + TO_LIMIT;
  assign to_fire_s = 1'b0;
`endif

  // Next-state decision; reset forces FETCH regardless of bus activity.
  always_comb begin
    next_s = FETCH;
    if (rst_i) begin
      next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (inst_ack_i)     next_s = DECODE;
          else if (to_fire_s) next_s = BERR;
          else                next_s = FETCH;
        end
        DECODE: begin
          if (is_halt_s)     next_s = irq_s ? INT : DECODE;
          else if (is_ctl_s) next_s = irq_target_s;
          else               next_s = EXEC;
        end
        EXEC: begin
          if (!is_mem_s)     next_s = WB;
          else if (mem_ack_s) next_s = mem_done_s;
          else               next_s = MEM;
        end
        MEM: begin
          if (mem_ack_s)      next_s = mem_done_s;
          else if (to_fire_s) next_s = BERR;
          else                next_s = MEM;
        end
        WB: begin
          next_s = irq_target_s;
        end
        INT: begin
          if (int_cnt_r == INT_LAST) next_s = FETCH;
          else                       next_s = INT;
        end
`ifdef CPU_CTRL_TIMEOUT_EN
        BERR: begin
          next_s = irq_target_s;
        end
`endif
        default: begin
          next_s = FETCH;
        end
      endcase
    end
  end

  // State register, dwell counters and Moore strobes registered against the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= FETCH;
      int_cnt_r  <= 4'd0;
      inst_cyc_o <= 1'b1;
      data_cyc_o <= 1'b0;
      data_we_o  <= 1'b0;
      port_cyc_o <= 1'b0;
      port_we_o  <= 1'b0;
      reg_we_o   <= 1'b0;
      int_ack_o  <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef CPU_CTRL_TIMEOUT_EN
      to_cnt_r   <= {TO_W{1'b0}};
`endif
    end else begin
      state_r    <= next_s;
      int_cnt_r  <= ((state_r == INT) && (next_s == INT)) ? int_cnt_r + 4'd1 : 4'd0;
      inst_cyc_o <= (next_s == FETCH);
      data_cyc_o <= bus_phase_s && is_mem_s && !mem_fn_s[1];
      data_we_o  <= bus_phase_s && is_mem_s && !mem_fn_s[1] && mem_fn_s[0];
      port_cyc_o <= bus_phase_s && is_mem_s && mem_fn_s[1];
      port_we_o  <= bus_phase_s && is_mem_s && mem_fn_s[1] && mem_fn_s[0];
      reg_we_o   <= (next_s == WB);
      int_ack_o  <= (next_s == INT);
`ifdef CPU_CTRL_TIMEOUT_EN
      bus_err_o  <= bus_err_o | (next_s == BERR);
      if (next_s != state_r) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if (((state_r == FETCH) && !inst_ack_i) || ((state_r == MEM) && !mem_ack_s)) begin
        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
        to_cnt_r <= to_cnt_r;
      end
`else
      bus_err_o  <= 1'b0;
`endif
    end
  end

  assign state_o      = state_r;
  assign next_state_o = next_s;

endmodule
